// File: rtl/mux_pipe_nto1_if.sv
// Bus interface for mux_pipe_nto1: select/data/control inputs and the
// pipelined result. The master modport drives operands and control, the
// slave modport (the mux itself) drives the result.
// Optional macro MUX_PIPE_PARITY_EN adds the out_par signal.
interface mux_pipe_nto1_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_IN     = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic                                 in_valid;
  logic                                 stall;
  logic                                 flush;
  logic [SEL_W-1:0]                     sel;
  logic [NUM_IN-1:0][DATA_WIDTH-1:0]    in;
  logic                                 err_clr;
  logic [DATA_WIDTH-1:0]                out;
  logic                                 out_valid;
  logic                                 sel_err;
`ifdef MUX_PIPE_PARITY_EN
  logic                                 out_par;
`endif

  modport master (
    output in_valid, stall, flush, sel, in, err_clr,
`ifdef MUX_PIPE_PARITY_EN
    input  out_par,
`endif
    input  out, out_valid, sel_err
  );

  modport slave (
    input  in_valid, stall, flush, sel, in, err_clr,
`ifdef MUX_PIPE_PARITY_EN
    output out_par,
`endif
    output out, out_valid, sel_err
  );
endinterface

// File: rtl/mux_pipe_nto1.sv
// Parametrised N:1 select multiplexer with a 1- or 2-stage registered output,
// stall/flush control and a sticky out-of-range select flag.
// Optional macro MUX_PIPE_PARITY_EN adds a registered even-parity bit (out_par)
// that travels with the data through the same stages.
module mux_pipe_nto1 #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_IN     = 4,
  parameter int STAGES     = 1
) (
  input logic            clk,
  input logic            reset,
  mux_pipe_nto1_if.slave bus
);
  localparam int               SEL_W    = $clog2(NUM_IN);
  // NUM_IN as an unsigned constant one bit wider than sel, so the range
  // comparison never truncates (NUM_IN = 16 needs five bits).
  localparam logic [SEL_W:0]   NUM_IN_W = NUM_IN[SEL_W:0];

  logic                               w_in_range;
  logic                               w_advance;
  logic [DATA_WIDTH-1:0]              w_d0;
  logic [STAGES-1:0][DATA_WIDTH-1:0]  r_data;
  logic [STAGES-1:0]                  r_valid;
  logic                               r_sel_err;

  assign w_in_range = ({1'b0, bus.sel} < NUM_IN_W);
  assign w_advance  = !bus.stall && !bus.flush;

  // Stage 0 select: out-of-range indices produce zero rather than aliasing.
  always_comb begin
    // NOTE: default assignment first so every path drives w_d0 and no latch is inferred.
    w_d0 = '0;
    if (w_in_range) begin
      w_d0 = bus.in[bus.sel];
    end
  end

  // Data/valid pipeline: flush kills valids only, stall holds, otherwise shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: data registers are reset too, because out must read zero during reset.
      r_data  <= '0;
      r_valid <= '0;
    end else if (bus.flush) begin
      r_valid <= '0;
    end else if (!bus.stall) begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
      r_data[0]  <= w_d0;
      r_valid[0] <= bus.in_valid;
      for (int s = 1; s < STAGES; s++) begin
        r_data[s]  <= r_data[s-1];
        r_valid[s] <= r_valid[s-1];
      end
    end
  end

  // Sticky error: set by an accepted out-of-range select, set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else if (w_advance && bus.in_valid && !w_in_range) begin
      r_sel_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_sel_err <= 1'b0;
    end
  end

  assign bus.out       = r_data[STAGES-1];
  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.sel_err   = r_sel_err;

`ifdef MUX_PIPE_PARITY_EN
  logic              w_par;
  logic [STAGES-1:0] r_par;

  assign w_par = ^w_d0;

  // Parity follows the data registers: untouched by flush, held by stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par <= '0;
    end else if (w_advance) begin
      r_par[0] <= w_par;
      for (int s = 1; s < STAGES; s++) begin
        r_par[s] <= r_par[s-1];
      end
    end
  end

  assign bus.out_par = r_par[STAGES-1];
`endif
endmodule
